// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: shared types for the memory-stage access unit.
// Provides the access size encoding, the load type handed to the extender,
// and the number of byte lanes on the data bus.
package dmem_access_unit_pkg;
    localparam int BYTE_LANES = 4;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } load_t;
endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: data-bus connection between the access unit and memory.
// Ports: addr/wdata/byte_en/ren/wen driven by the master (access unit);
// busy/rdata driven by the slave (memory); a transfer ends when busy is low
// while a strobe is high.
interface dmem_access_unit_if;
    import dmem_access_unit_pkg::*;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [BYTE_LANES-1:0] byte_en;
    logic                  ren;
    logic                  wen;
    logic                  busy;
    logic [31:0]           rdata;
    modport master(output addr, wdata, byte_en, ren, wen, input busy, rdata);
    modport slave(input addr, wdata, byte_en, ren, wen, output busy, rdata);
endinterface

// File: rtl/dmem_access_unit_lane_gen.sv
// dmem_access_unit_lane_gen: combinational lane decode for one access.
// Ports: size/addr_lo/wdata in; lanes (active byte enables), lane_wdata
// (store data replicated across lanes) and misaligned (illegal size or
// unaligned address) out.
module dmem_access_unit_lane_gen
    import dmem_access_unit_pkg::*;
(
    input  mem_size_t             size,
    input  logic [1:0]            addr_lo,
    input  logic [31:0]           wdata,
    output logic [BYTE_LANES-1:0] lanes,
    output logic [31:0]           lane_wdata,
    output logic                  misaligned
);
    assign lanes = size == SZ_BYTE ? 4'b0001 << addr_lo :
                   size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_wdata = size == SZ_BYTE ? {4{wdata[7:0]}} :
                        size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    assign misaligned = (size == SZ_ILL) | ((size == SZ_HALF) & addr_lo[0]) |
                        ((size == SZ_WORD) & (|addr_lo));
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage front end for loads and stores.
// Ports: clk/rst (async active-high); req_* request from execute with
// req_ready handshake; flush squashes the in-flight result; bus is the
// data-bus master; dmem_in/byte_en/load_type are the registered result for
// the extender, qualified by the one-cycle done pulse; misaligned and
// bus_fault are one-cycle fault pulses.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_ren,
    input  logic                  req_wen,
    input  mem_size_t             req_size,
    input  load_t                 req_load_type,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  flush,
    dmem_access_unit_if.master    bus,
    output logic [31:0]           dmem_in,
    output logic [BYTE_LANES-1:0] byte_en,
    output load_t                 load_type,
    output logic                  done,
    output logic                  misaligned,
    output logic                  bus_fault
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic {IDLE, BUS} state_t;
    state_t                state, state_nx;
    logic [BYTE_LANES-1:0] lanes;
    logic [31:0]           lane_wdata;
    logic                  lane_mis;
    logic                  accept, illegal, complete, expire, kill;
    logic [CW-1:0]         cnt;
    load_t                 pend_lt;
    dmem_access_unit_lane_gen u_lane_gen (
        .size       (req_size),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .lanes      (lanes),
        .lane_wdata (lane_wdata),
        .misaligned (lane_mis)
    );
    // A flush in the accept cycle drops the request entirely, faults included.
    assign accept   = req_valid & req_ready & (req_ren | req_wen) & ~flush;
    assign illegal  = lane_mis | (req_ren & req_wen);
    assign complete = (state == BUS) & ~bus.busy;
    // Completion outranks timeout because expire requires busy still high.
    assign expire   = (state == BUS) & bus.busy & (TIMEOUT_CYCLES != 0) &
                      (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        req_ready = state == IDLE;
        state_nx  = state == IDLE ? (accept & ~illegal ? BUS : IDLE) :
                                    (complete | expire ? IDLE : BUS);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.addr    <= '0;
            bus.wdata   <= '0;
            bus.byte_en <= '0;
            bus.ren     <= 1'b0;
            bus.wen     <= 1'b0;
            dmem_in     <= '0;
            byte_en     <= '0;
            load_type   <= LD_W;
            pend_lt     <= LD_W;
            done        <= 1'b0;
            misaligned  <= 1'b0;
            bus_fault   <= 1'b0;
            kill        <= 1'b0;
            cnt         <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= accept & illegal;
            bus_fault  <= expire;
            if (accept & ~illegal) begin
                bus.addr    <= {req_addr[31:2], 2'b00};
                bus.wdata   <= lane_wdata;
                bus.byte_en <= lanes;
                bus.ren     <= req_ren;
                bus.wen     <= req_wen;
                pend_lt     <= req_load_type;
                cnt         <= '0;
                kill        <= 1'b0;
            end
            if (state == BUS) begin
                cnt <= cnt + 1'b1;
                if (flush) kill <= 1'b1;
                if (complete | expire) begin
                    bus.ren <= 1'b0;
                    bus.wen <= 1'b0;
                    kill    <= 1'b0;
                end
                // A squashed access still finishes on the bus but leaves no trace downstream.
                if (complete & ~kill & ~flush) begin
                    done      <= 1'b1;
                    dmem_in   <= bus.ren ? bus.rdata : '0;
                    byte_en   <= bus.byte_en;
                    load_type <= pend_lt;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: self-checking bench for dmem_access_unit.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;
    localparam int TO = 4;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ren = 0, req_wen = 0, flush = 0;
    mem_size_t   req_size = SZ_BYTE;
    load_t       req_load_type = LD_W;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, done, misaligned, bus_fault;
    logic [31:0] dmem_in;
    logic [3:0]  byte_en;
    load_t       load_type;
    dmem_access_unit_if bus();
    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ren(req_ren), .req_wen(req_wen), .req_size(req_size),
        .req_load_type(req_load_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush), .bus(bus), .dmem_in(dmem_in), .byte_en(byte_en),
        .load_type(load_type), .done(done), .misaligned(misaligned), .bus_fault(bus_fault)
    );
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: holds busy for busy_cycles strobe cycles, then completes.
    int busy_cycles = 0, scnt = 0;
    logic [31:0] rdata_val = 0;
    initial begin
        bus.busy = 0;
        bus.rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.ren | bus.wen) begin
                bus.busy = scnt < busy_cycles;
                scnt++;
            end else begin
                scnt = 0;
                bus.busy = 0;
            end
            bus.rdata = rdata_val;
        end
    end

    // Transaction-level reference model.
    logic        m_act = 0, m_load = 0, m_kill = 0;
    int          m_age = 0;
    logic [31:0] m_addr = 0, m_wd = 0;
    logic [3:0]  m_lanes = 0;
    load_t       m_lt = LD_W;
    logic        e_ready, e_done, e_mis, e_flt, e_ren, e_wen;
    logic [31:0] e_dmem;
    logic [3:0]  e_be;
    load_t       e_lt;

    task automatic model_reset();
        m_act = 0; m_kill = 0; m_age = 0;
        e_ready = 1; e_done = 0; e_mis = 0; e_flt = 0; e_ren = 0; e_wen = 0;
        e_dmem = 0; e_be = 0; e_lt = LD_W;
    endtask

    task automatic model_step();
        int n;
        e_done = 0; e_mis = 0; e_flt = 0;
        if (m_act) begin
            if (flush) m_kill = 1;
            if (!bus.busy) begin
                m_act = 0;
                if (!m_kill) begin
                    e_done = 1;
                    e_dmem = m_load ? bus.rdata : 32'h0;
                    e_be = m_lanes;
                    e_lt = m_lt;
                end
            end else begin
                m_age++;
                if (m_age == TO) begin
                    m_act = 0;
                    e_flt = 1;
                end
            end
        end else if (req_valid && (req_ren || req_wen) && !flush) begin
            n = 1 << req_size;
            if (req_size == SZ_ILL || (req_ren && req_wen) || (req_addr % n) != 0) e_mis = 1;
            else begin
                m_act = 1; m_kill = 0; m_age = 0; m_load = req_ren; m_lt = req_load_type;
                m_addr = req_addr & ~32'd3;
                m_lanes = 4'(((1 << n) - 1) << (req_addr % 4));
                for (int k = 0; k < 4; k++) m_wd[8*k +: 8] = req_wdata[8*(k % n) +: 8];
            end
        end
        e_ren = m_act & m_load;
        e_wen = m_act & !m_load;
        e_ready = !m_act;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        check("ready", req_ready, e_ready);
        check("done", done, e_done);
        check("misaligned", misaligned, e_mis);
        check("bus_fault", bus_fault, e_flt);
        check("bus_ren", bus.ren, e_ren);
        check("bus_wen", bus.wen, e_wen);
        check("dmem_in", dmem_in, e_dmem);
        check("byte_en", byte_en, e_be);
        check("load_type", load_type, e_lt);
        if (e_ren | e_wen) begin
            check("bus_addr", bus.addr, m_addr);
            check("bus_wdata", bus.wdata, m_wd);
            check("bus_byte_en", bus.byte_en, m_lanes);
        end
    end

    // One request, then 10 observed cycles; reports strobe count and pulse cycles.
    task automatic access(input logic ren, input logic wen, input mem_size_t sz, input load_t lt,
                          input logic [31:0] a, input logic [31:0] wd, input int busy, input int fl_at,
                          output int strobes, output int done_at, output int mis_at, output int flt_at,
                          output logic [3:0] be1, output logic [31:0] wd1);
        strobes = 0; done_at = -1; mis_at = -1; flt_at = -1; be1 = 0; wd1 = 0;
        busy_cycles = busy;
        @(posedge clk); #1;
        req_valid = 1; req_ren = ren; req_wen = wen; req_size = sz; req_load_type = lt;
        req_addr = a; req_wdata = wd; flush = (fl_at == 0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            req_valid = 0; req_ren = 0; req_wen = 0; flush = (fl_at == c);
            @(negedge clk);
            if (bus.ren | bus.wen) strobes++;
            if (c == 1) begin be1 = bus.byte_en; wd1 = bus.wdata; end
            if (done && done_at < 0) done_at = c;
            if (misaligned && mis_at < 0) mis_at = c;
            if (bus_fault && flt_at < 0) flt_at = c;
        end
    endtask

    int s, d, m, f;
    logic [3:0] be;
    logic [31:0] wd;
    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_dmem", dmem_in, 0);
        check("rst_ren", bus.ren, 0);
        @(posedge clk); #1 rst = 0;

        rdata_val = 32'hBEEF1234;
        access(1, 0, SZ_HALF, LD_H, 32'h1002, 0, 0, -1, s, d, m, f, be, wd);
        check("lh_strobes", s, 1);
        check("lh_done_at", d, 2);
        check("lh_lanes", be, 4'b1100);
        check("lh_dmem", dmem_in, 32'hBEEF1234);
        check("lh_byte_en", byte_en, 4'b1100);
        check("lh_type", load_type, LD_H);

        access(0, 1, SZ_BYTE, LD_W, 32'h103, 32'hA5, 3, -1, s, d, m, f, be, wd);
        check("sb_strobes", s, 4);
        check("sb_done_at", d, 5);
        check("sb_lanes", be, 4'b1000);
        check("sb_wdata", wd, 32'hA5A5A5A5);
        check("sb_dmem", dmem_in, 0);

        access(1, 0, SZ_WORD, LD_W, 32'h2002, 0, 0, -1, s, d, m, f, be, wd);
        check("lw_mis_at", m, 1);
        check("lw_mis_strobes", s, 0);
        check("lw_mis_done", d, -1);

        access(1, 1, SZ_WORD, LD_W, 32'h2000, 0, 0, -1, s, d, m, f, be, wd);
        check("rw_mis_at", m, 1);
        check("rw_mis_strobes", s, 0);

        access(1, 0, SZ_ILL, LD_W, 32'h2000, 0, 0, -1, s, d, m, f, be, wd);
        check("ill_mis_at", m, 1);

        access(0, 1, SZ_HALF, LD_W, 32'h2001, 0, 0, -1, s, d, m, f, be, wd);
        check("sh_mis_at", m, 1);

        rdata_val = 32'h11223344;
        access(1, 0, SZ_WORD, LD_W, 32'h2004, 0, 1, -1, s, d, m, f, be, wd);
        check("lw_done_at", d, 3);
        check("lw_dmem", dmem_in, 32'h11223344);
        check("lw_byte_en", byte_en, 4'b1111);

        rdata_val = 32'hDEADBEEF;
        access(1, 0, SZ_BYTE, LD_B, 32'h3001, 0, 2, 2, s, d, m, f, be, wd);
        check("flush_strobes", s, 3);
        check("flush_done", d, -1);
        check("flush_dmem", dmem_in, 32'h11223344);
        check("flush_type", load_type, LD_W);

        access(1, 0, SZ_WORD, LD_W, 32'h3000, 0, 0, 0, s, d, m, f, be, wd);
        check("flush0_strobes", s, 0);
        check("flush0_done", d, -1);

        access(0, 1, SZ_HALF, LD_W, 32'h2006, 32'h0000CAFE, 0, -1, s, d, m, f, be, wd);
        check("sh_wdata", wd, 32'hCAFECAFE);
        check("sh_lanes", be, 4'b1100);
        check("sh_done_at", d, 2);

        access(0, 0, SZ_WORD, LD_W, 32'h2000, 0, 0, -1, s, d, m, f, be, wd);
        check("none_strobes", s, 0);
        check("none_mis", m, -1);

        access(1, 0, SZ_WORD, LD_W, 32'h2008, 0, 100, -1, s, d, m, f, be, wd);
        check("to_strobes", s, 4);
        check("to_fault_at", f, 5);
        check("to_done", d, -1);
        check("to_ready", req_ready, 1);

        busy_cycles = 100;
        @(posedge clk); #1;
        req_valid = 1; req_ren = 1; req_size = SZ_WORD; req_load_type = LD_HU; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 0; req_ren = 0;
        @(posedge clk); #1;
        check("pre_rst_ren", bus.ren, 1);
        rst = 1;
        #1;
        check("rst_mid_ren", bus.ren, 0);
        check("rst_mid_addr", bus.addr, 0);
        check("rst_mid_dmem", dmem_in, 0);
        check("rst_mid_be", byte_en, 0);
        check("rst_mid_type", load_type, LD_W);
        check("rst_mid_ready", req_ready, 1);
        @(posedge clk); #1 rst = 0;
        repeat (3) @(posedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
